// File: rtl/windowed_reg_file.sv
// Register file with overlapping sliding windows: window w exposes NREG registers
// starting at physical index w*STEP, wrapping modulo PHYS.
module windowed_reg_file #(
  parameter int DW     = 16,
  parameter int NWIN   = 4,
  parameter int NREG   = 4,
  parameter int OVL    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG),
  localparam int WW    = $clog2(NWIN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          we,
  input  logic          call,
  input  logic          ret,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic [WW-1:0] cwp,
  output logic [WW:0]   used,
  output logic          ovf,
  output logic          unf
);
  localparam int STEP = NREG - OVL;
  localparam int PHYS = NWIN * STEP;
  localparam int PW   = (PHYS > 1) ? $clog2(PHYS) : 1;

  // Window-relative to physical index; PHYS need not be a power of two.
  function automatic logic [PW-1:0] f_map(input logic [WW-1:0] w, input logic [AW-1:0] a);
    logic [31:0] s;
    s = 32'(w) * 32'(STEP) + 32'(a);
    return PW'(s % 32'(PHYS));
  endfunction

  logic [PHYS-1:0][DW-1:0] r_regs;
  logic [WW-1:0]           r_cwp;
  logic [WW:0]             r_used;
  logic                    r_ovf;
  logic                    r_unf;

  logic [PW-1:0] w_rp1, w_rp2, w_wp;
  logic          w_fwd1, w_fwd2;

  assign w_rp1 = f_map(r_cwp, ra1);
  assign w_rp2 = f_map(r_cwp, ra2);
  assign w_wp  = f_map(r_cwp, wa);

  // Forwarding is suppressed during reset so reads show the cleared storage.
  assign w_fwd1 = (BYPASS != 0) && we && !rst && (w_rp1 == w_wp);
  assign w_fwd2 = (BYPASS != 0) && we && !rst && (w_rp2 == w_wp);

  assign rd1 = w_fwd1 ? wd : r_regs[w_rp1];
  assign rd2 = w_fwd2 ? wd : r_regs[w_rp2];

  genvar g;
  generate
    for (g = 0; g < PHYS; g++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_regs[g] <= '0;
        else if (we && (w_wp == PW'(g)))  r_regs[g] <= wd;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cwp  <= '0;
      r_used <= (WW+1)'(1);
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (call && !ret) begin
        if (r_used == (WW+1)'(NWIN)) begin
          r_ovf <= 1'b1;
        end else begin
          r_cwp  <= r_cwp + 1'b1;
          r_used <= r_used + 1'b1;
        end
      end else if (ret && !call) begin
        if (r_used == (WW+1)'(1)) begin
          r_unf <= 1'b1;
        end else begin
          r_cwp  <= r_cwp - 1'b1;
          r_used <= r_used - 1'b1;
        end
      end
    end
  end

  assign cwp  = r_cwp;
  assign used = r_used;
  assign ovf  = r_ovf;
  assign unf  = r_unf;
endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed plus random checks of windowed_reg_file against an array-based model,
// with forwarding enabled and disabled instances sharing one stimulus.
module tb_windowed_reg_file;
  localparam int DW = 16, NWIN = 4, NREG = 4, OVL = 2;
  localparam int STEP = NREG - OVL, PHYS = NWIN * STEP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    ra1 = '0, ra2 = '0, wa = '0;
  logic [DW-1:0] wd = '0;
  logic          we = 1'b0, call = 1'b0, ret = 1'b0;
  logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [1:0]    cwp_b, cwp_n;
  logic [2:0]    used_b, used_n;
  logic          ovf_b, unf_b, ovf_n, unf_n;

  windowed_reg_file #(.DW(DW), .NWIN(NWIN), .NREG(NREG), .OVL(OVL), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd), .we(we),
    .call(call), .ret(ret), .rd1(rd1_b), .rd2(rd2_b), .cwp(cwp_b), .used(used_b),
    .ovf(ovf_b), .unf(unf_b));

  windowed_reg_file #(.DW(DW), .NWIN(NWIN), .NREG(NREG), .OVL(OVL), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd), .we(we),
    .call(call), .ret(ret), .rd1(rd1_n), .rd2(rd2_n), .cwp(cwp_n), .used(used_n),
    .ovf(ovf_n), .unf(unf_n));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  logic [DW-1:0] mem [PHYS];
  int m_cwp, m_used, m_ovf, m_unf;

  function automatic int pm(input int w, input int a);
    return (w * STEP + a) % PHYS;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PHYS; i++) mem[i] = '0;
    m_cwp = 0; m_used = 1; m_ovf = 0; m_unf = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".cwp"},  32'(cwp_b),  32'(m_cwp));
    chk({tag, ".cwpn"}, 32'(cwp_n),  32'(m_cwp));
    chk({tag, ".used"}, 32'(used_b), 32'(m_used));
    chk({tag, ".ovf"},  32'(ovf_b),  32'(m_ovf));
    chk({tag, ".unf"},  32'(unf_b),  32'(m_unf));
    chk({tag, ".ovfn"}, 32'(ovf_n),  32'(m_ovf));
    chk({tag, ".unfn"}, 32'(unf_n),  32'(m_unf));
  endtask

  // Expected read value: forwarding applies only to the BYPASS=1 instance.
  task automatic chk_reads(input string tag);
    int p1, p2, pw;
    p1 = pm(m_cwp, int'(ra1)); p2 = pm(m_cwp, int'(ra2)); pw = pm(m_cwp, int'(wa));
    chk({tag, ".rd1b"}, 32'(rd1_b), 32'((we && p1 == pw) ? wd : mem[p1]));
    chk({tag, ".rd2b"}, 32'(rd2_b), 32'((we && p2 == pw) ? wd : mem[p2]));
    chk({tag, ".rd1n"}, 32'(rd1_n), 32'(mem[p1]));
    chk({tag, ".rd2n"}, 32'(rd2_n), 32'(mem[p2]));
  endtask

  // One clock cycle: apply inputs, check combinational reads, clock, check state.
  task automatic cyc(input string tag, input logic i_we, input int i_wa, input int i_wd,
                     input logic i_call, input logic i_ret, input int i_ra1, input int i_ra2);
    we = i_we; wa = 2'(i_wa); wd = DW'(i_wd); call = i_call; ret = i_ret;
    ra1 = 2'(i_ra1); ra2 = 2'(i_ra2);
    #1;
    chk_reads(tag);
    @(posedge clk); #1;
    m_ovf = 0; m_unf = 0;
    if (i_we) mem[pm(m_cwp, i_wa)] = DW'(i_wd);
    if (i_call && !i_ret) begin
      if (m_used == NWIN) m_ovf = 1;
      else begin m_cwp = (m_cwp + 1) % NWIN; m_used++; end
    end else if (i_ret && !i_call) begin
      if (m_used == 1) m_unf = 1;
      else begin m_cwp = (m_cwp + NWIN - 1) % NWIN; m_used--; end
    end
    chk_state(tag);
  endtask

  task automatic idle_rd(input string tag, input int a1, input logic [DW-1:0] exp);
    cyc(tag, 1'b0, 0, 0, 1'b0, 1'b0, a1, a1);
    chk({tag, ".const"}, 32'(rd1_b), 32'(exp));
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    for (int a = 0; a < NREG; a++) begin
      ra1 = 2'(a); #1;
      chk("rst.rd1", 32'(rd1_b), 32'h0);
    end
    chk_state("rst");
    @(negedge clk); rst = 1'b0; ra1 = '0;
    @(posedge clk); #1;
    chk_state("rel");

    // Underflow and simultaneous call+ret
    cyc("unf", 1'b0, 0, 0, 1'b0, 1'b1, 0, 0);
    chk("unf.pulse", 32'(unf_b), 32'h1);
    cyc("unf2", 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    cyc("both", 1'b0, 0, 0, 1'b1, 1'b1, 0, 0);
    chk("both.cwp", 32'(cwp_b), 32'h0);

    // Overlap: window 0 reg 2 is window 1 reg 0
    cyc("w35", 1'b1, 2, 16'hABCD, 1'b0, 1'b0, 0, 0);
    cyc("c35", 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
    chk("c35.cwp", 32'(cwp_b), 32'h1);
    idle_rd("r35a", 0, 16'hABCD);
    cyc("ret35", 1'b0, 0, 0, 1'b0, 1'b1, 0, 0);
    idle_rd("r35b", 2, 16'hABCD);

    // Fill all windows, wrap write to physical 0, overflow
    for (int i = 0; i < 3; i++) cyc("c36", 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
    chk("c36.used", 32'(used_b), 32'h4);
    cyc("w36", 1'b1, 2, 16'h1234, 1'b0, 1'b0, 0, 0);
    cyc("ovf", 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
    chk("ovf.pulse", 32'(ovf_b), 32'h1);
    chk("ovf.cwp", 32'(cwp_b), 32'h3);
    cyc("ovf2", 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("r36", 1'b0, 0, 0, 1'b0, 1'b1, 0, 0);
    idle_rd("r36c", 0, 16'h1234);

    // Forwarding vs. stored value before the edge
    we = 1'b1; wa = 2'd1; wd = 16'h5A5A; ra2 = 2'd1; #1;
    chk("byp.rd2b", 32'(rd2_b), 32'h5A5A);
    chk("byp.rd2n", 32'(rd2_n), 32'h0);
    cyc("byp", 1'b1, 1, 16'h5A5A, 1'b0, 1'b0, 0, 1);
    cyc("byp2", 1'b0, 0, 0, 1'b0, 1'b0, 0, 1);
    chk("byp2.rd2n", 32'(rd2_n), 32'h5A5A);

    // Write concurrent with call uses the old window
    cyc("w39", 1'b1, 3, 16'h7777, 1'b1, 1'b0, 0, 0);
    idle_rd("r39", 1, 16'h7777);

    // Asynchronous reset mid-cycle with pending write and call
    we = 1'b1; wa = 2'd1; wd = 16'hFFFF; call = 1'b1; ra1 = 2'd1; ra2 = 2'd1; #1;
    rst = 1'b1; #1;
    chk("arst.rd1b", 32'(rd1_b), 32'h0);
    chk("arst.rd2b", 32'(rd2_b), 32'h0);
    chk("arst.rd1n", 32'(rd1_n), 32'h0);
    model_reset();
    chk_state("arst");
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; we = 1'b0; call = 1'b0;
    @(posedge clk); #1;
    chk_state("arel");
    idle_rd("arel.rd", 1, 16'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r, a1, a2, aw;
      r  = int'($urandom_range(0, 9));
      aw = int'($urandom_range(0, 3));
      a1 = int'($urandom_range(0, 3));
      a2 = ($urandom_range(0, 2) == 0) ? aw : int'($urandom_range(0, 3));
      cyc("rnd", 1'($urandom_range(0, 1)), aw, int'($urandom_range(0, 16'hFFFF)),
          (r < 4) || (r == 8), (r >= 4 && r <= 7) || (r == 8), a1, a2);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/windowed_reg_file.md
WINDOWED_REG_FILE -- requirements
Module: windowed_reg_file

Interface
REQ-001 SHALL provide parameter DW, 16, data width in bits.
REQ-002 SHALL provide parameter NWIN, 4, number of register windows (power of 2, >=2).
REQ-003 SHALL provide parameter NREG, 4, architecturally visible registers per window (power of 2, >=2).
REQ-004 SHALL provide parameter OVL, 2, registers shared between adjacent windows (0 <= OVL < NREG).
REQ-005 SHALL provide parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-006 SHALL derive AW = log2(NREG), WW = log2(NWIN), STEP = NREG-OVL, PHYS = NWIN*STEP physical registers.
REQ-007 SHALL provide port clk  input  1  rising-edge clock.
REQ-008 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL provide ports ra1, ra2  input  AW  read addresses, window-relative.
REQ-010 SHALL provide port wa  input  AW  write address, window-relative.
REQ-011 SHALL provide port wd  input  DW  write data.
REQ-012 SHALL provide port we  input  1  write enable.
REQ-013 SHALL provide port call  input  1  open next window (cwp+1).
REQ-014 SHALL provide port ret  input  1  return to previous window (cwp-1).
REQ-015 SHALL provide ports rd1, rd2  output  DW  read data, combinational.
REQ-016 SHALL provide port cwp  output  WW  current window pointer.
REQ-017 SHALL provide port used  output  WW+1  number of active windows.
REQ-018 SHALL provide ports ovf, unf  output  1  window overflow / underflow, one-cycle registered pulses.

Function
REQ-019 SHALL map window-relative address a in window w to physical index (w*STEP + a) mod PHYS, for both reads and writes.
REQ-020 SHALL drive rd1/rd2 combinationally from the physical register selected by ra1/ra2 and the current cwp.
REQ-021 SHALL, on rising clk with we=1, write wd to the physical register selected by wa and the pre-edge cwp.
REQ-022 SHALL, with BYPASS=1 and we=1, drive wd on rdN whenever raN maps to the same physical index as wa; with BYPASS=0, rdN shows the stored value until the edge.
REQ-023 SHALL, on a clk edge with call=1, ret=0 and used<NWIN, increment cwp modulo NWIN and increment used.
REQ-024 SHALL, on a clk edge with ret=1, call=0 and used>1, decrement cwp modulo NWIN and decrement used.
REQ-025 SHALL, on call=1 with used==NWIN, leave cwp/used unchanged and assert ovf for exactly the following cycle.
REQ-026 SHALL, on ret=1 with used==1, leave cwp/used unchanged and assert unf for exactly the following cycle.
REQ-027 SHALL treat call=1 and ret=1 in the same cycle as a no-op: no cwp/used change, no ovf/unf.
REQ-028 SHALL allow a write in the same cycle as call/ret; the write uses the pre-edge cwp.
REQ-029 SHALL wrap cwp NWIN-1 -> 0 on call and 0 -> NWIN-1 on ret; physical indices wrap modulo PHYS.
REQ-030 SHALL preserve register contents across window changes; only writes modify storage.

Reset
REQ-031 SHALL, while rst=1, force all PHYS registers to 0, cwp=0, used=1, ovf=0, unf=0, independent of clk.
REQ-032 SHALL, on rst asserted mid-operation, discard any pending write/call/ret of that cycle; rd1/rd2 read 0 immediately.
REQ-033 SHALL resume normal operation on the first rising clk after rst deasserts.

Verification (defaults: DW=16, NWIN=4, NREG=4, OVL=2, PHYS=8)
REQ-034 Reset then read ra1=0..3 -> rd1=0x0000, cwp=0, used=1, ovf=unf=0.
REQ-035 cwp=0: write wa=2 wd=0xABCD, then call -> cwp=1; ra1=0 -> rd1=0xABCD (overlap); ret, ra1=2 -> 0xABCD.
REQ-036 Three calls -> cwp=3, used=4; write wa=2 wd=0x1234 -> physical 0; fourth call -> ovf pulse one cycle, cwp=3, used=4; ret x3 to cwp=0, ra1=0 -> 0x1234.
REQ-037 After reset, ret -> unf pulse one cycle, cwp=0, used=1; call+ret same cycle -> no change, no pulses.
REQ-038 BYPASS=1: we=1 wa=1 wd=0x5A5A with ra2=1 in same cycle -> rd2=0x5A5A before the edge; BYPASS=0 -> old value until edge.
REQ-039 Write wa=3 wd=0x7777 concurrent with call at cwp=0 -> physical 3 written; in cwp=1, ra1=1 -> 0x7777; rst mid-sequence -> rd1=0 immediately.
